// File: rtl/axi_stream_fcmp.sv
// Three-channel AXI-Stream IEEE-754 single-precision comparator (LT / EQ / LE).
// Each input channel has a one-entry slot; a full operand set fires into a one-entry result register.
module axi_stream_fcmp #(
  parameter int OP_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     fcmp_a_tdata,
  input  logic            fcmp_a_tvalid,
  output logic            fcmp_a_tready,
  input  logic [31:0]     fcmp_b_tdata,
  input  logic            fcmp_b_tvalid,
  output logic            fcmp_b_tready,
  input  logic [OP_W-1:0] fcmp_operation_tdata,
  input  logic            fcmp_operation_tvalid,
  output logic            fcmp_operation_tready,
  output logic [OP_W-1:0] fcmp_r_tdata,
  output logic            fcmp_r_tvalid,
  input  logic            fcmp_r_tready
);

  typedef enum logic [2:0] {
    OP_LT = 3'b001,
    OP_EQ = 3'b010,
    OP_LE = 3'b011
  } cmp_op_e;

  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic        a_full, b_full, op_full;
  logic        r_valid;
  logic [OP_W-1:0] r_data;
  logic        fire;
  logic        a_nan, b_nan, both_zero, lt, eq, cond;

  // Only the op-code field [5:3] carries meaning; the rest of the op word is dropped.
  logic unused_op_bits;
  assign unused_op_bits = ^{fcmp_operation_tdata[OP_W-1:6], fcmp_operation_tdata[2:0]};

  // Ready comes straight from the full flags, so no tvalid/tready path is combinational.
  assign fcmp_a_tready         = !a_full;
  assign fcmp_b_tready         = !b_full;
  assign fcmp_operation_tready = !op_full;
  assign fcmp_r_tvalid         = r_valid;
  assign fcmp_r_tdata          = r_data;

  assign fire = a_full && b_full && op_full && (!r_valid || fcmp_r_tready);

  always_comb begin
    // NOTE: every output of this block is assigned before any branch so no latch is inferred.
    lt        = 1'b0;
    cond      = 1'b0;
    a_nan     = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan     = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    both_zero = (a_q[30:0] == 31'd0) && (b_q[30:0] == 31'd0);
    eq        = !a_nan && !b_nan && ((a_q == b_q) || both_zero);
    if (!a_nan && !b_nan && !both_zero) begin
      case ({a_q[31], b_q[31]})
        2'b00:   lt = a_q[30:0] < b_q[30:0];
        2'b10:   lt = 1'b1;
        2'b11:   lt = b_q[30:0] < a_q[30:0];  // both negative: larger magnitude is smaller
        default: lt = 1'b0;
      endcase
    end
    case (op_q)
      OP_LT:   cond = lt;
      OP_EQ:   cond = eq;
      OP_LE:   cond = lt || eq;
      default: cond = 1'b0;
    endcase
  end

  // NOTE: operand data registers carry no reset; their full flags alone decide validity.
  always_ff @(posedge clk) begin
    if (fcmp_a_tvalid && !a_full)         a_q  <= fcmp_a_tdata;
    if (fcmp_b_tvalid && !b_full)         b_q  <= fcmp_b_tdata;
    if (fcmp_operation_tvalid && !op_full) op_q <= fcmp_operation_tdata[5:3];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_full  <= 1'b0;
      b_full  <= 1'b0;
      op_full <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      // Fire needs every slot full, so a slot never accepts and clears in the same cycle.
      if (fcmp_a_tvalid && !a_full)          a_full  <= 1'b1;
      else if (fire)                         a_full  <= 1'b0;
      if (fcmp_b_tvalid && !b_full)          b_full  <= 1'b1;
      else if (fire)                         b_full  <= 1'b0;
      if (fcmp_operation_tvalid && !op_full) op_full <= 1'b1;
      else if (fire)                         op_full <= 1'b0;

      if (fire) begin
        r_valid <= 1'b1;
        r_data  <= {{(OP_W-1){1'b0}}, cond};
      end else if (fcmp_r_tready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_fcmp.sv
// Scoreboard bench for axi_stream_fcmp: expected results are queued as operands are driven
// and popped when the result channel handshakes.
module tb_axi_stream_fcmp;
  localparam int OP_W = 8;
  localparam int N_RAND = 1000;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     fcmp_a_tdata, fcmp_b_tdata;
  logic            fcmp_a_tvalid, fcmp_a_tready, fcmp_b_tvalid, fcmp_b_tready;
  logic [OP_W-1:0] fcmp_operation_tdata, fcmp_r_tdata;
  logic            fcmp_operation_tvalid, fcmp_operation_tready;
  logic            fcmp_r_tvalid, fcmp_r_tready;

  int vectors = 0;
  int miscompares = 0;
  bit abort = 1'b0;
  logic [OP_W-1:0] exp_q[$];
  logic [31:0]     ra[N_RAND];
  logic [31:0]     rb[N_RAND];
  logic [OP_W-1:0] rop[N_RAND];

  axi_stream_fcmp #(.OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .fcmp_a_tdata(fcmp_a_tdata), .fcmp_a_tvalid(fcmp_a_tvalid), .fcmp_a_tready(fcmp_a_tready),
    .fcmp_b_tdata(fcmp_b_tdata), .fcmp_b_tvalid(fcmp_b_tvalid), .fcmp_b_tready(fcmp_b_tready),
    .fcmp_operation_tdata(fcmp_operation_tdata), .fcmp_operation_tvalid(fcmp_operation_tvalid),
    .fcmp_operation_tready(fcmp_operation_tready),
    .fcmp_r_tdata(fcmp_r_tdata), .fcmp_r_tvalid(fcmp_r_tvalid), .fcmp_r_tready(fcmp_r_tready)
  );

  always #5 clk = ~clk;

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Reference: map each float onto a signed integer line where -0 and +0 coincide.
  function automatic logic [OP_W-1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                              input logic [OP_W-1:0] op);
    logic signed [32:0] ka, kb;
    logic r;
    if (is_nan(a) || is_nan(b)) return '0;
    ka = $signed({2'b00, a[30:0]});
    kb = $signed({2'b00, b[30:0]});
    if (a[31]) ka = -ka;
    if (b[31]) kb = -kb;
    case (op[5:3])
      3'd1:    r = (ka < kb);
      3'd2:    r = (ka == kb);
      3'd3:    r = (ka <= kb);
      default: r = 1'b0;
    endcase
    return {{(OP_W-1){1'b0}}, r};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v = 32'h0000_0000;
      1: v = 32'h8000_0000;
      2: v = 32'h7F80_0000;
      3: v = 32'hFF80_0000;
      4: v = {v[31], 8'hFF, 22'd0, 1'b1} | {9'd0, v[22:0]};
      5: v = {v[31], 8'h00, v[22:0]};
      6: v = ($urandom_range(0, 1) != 0) ? 32'h3F80_0000 : 32'hBF80_0000;
      default: ;
    endcase
    return v;
  endfunction

  // Drivers start just after a rising edge and return just after the accepting edge.
  task automatic put_a(input logic [31:0] d, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    fcmp_a_tdata = d; fcmp_a_tvalid = 1'b1;
    while (!abort) begin
      @(negedge clk);
      if (fcmp_a_tready) break;
      n++;
      if (n > 200) begin
        miscompares++; abort = 1'b1;
        $display("FAIL a_accept_timeout: tready still 0 after %0d cycles, want 1", n);
      end
    end
    @(posedge clk); #1;
    fcmp_a_tvalid = 1'b0; fcmp_a_tdata = $urandom;
  endtask

  task automatic put_b(input logic [31:0] d, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    fcmp_b_tdata = d; fcmp_b_tvalid = 1'b1;
    while (!abort) begin
      @(negedge clk);
      if (fcmp_b_tready) break;
      n++;
      if (n > 200) begin
        miscompares++; abort = 1'b1;
        $display("FAIL b_accept_timeout: tready still 0 after %0d cycles, want 1", n);
      end
    end
    @(posedge clk); #1;
    fcmp_b_tvalid = 1'b0; fcmp_b_tdata = $urandom;
  endtask

  task automatic put_op(input logic [OP_W-1:0] d, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    fcmp_operation_tdata = d; fcmp_operation_tvalid = 1'b1;
    while (!abort) begin
      @(negedge clk);
      if (fcmp_operation_tready) break;
      n++;
      if (n > 200) begin
        miscompares++; abort = 1'b1;
        $display("FAIL op_accept_timeout: tready still 0 after %0d cycles, want 1", n);
      end
    end
    @(posedge clk); #1;
    fcmp_operation_tvalid = 1'b0; fcmp_operation_tdata = OP_W'($urandom);
  endtask

  task automatic send_set(input logic [31:0] a, input logic [31:0] b, input logic [OP_W-1:0] op);
    exp_q.push_back(ref_cmp(a, b, op));
    fork
      put_a(a, 0);
      put_b(b, 0);
      put_op(op, 0);
    join
  endtask

  task automatic pop_check(input string name);
    int n = 0;
    logic [OP_W-1:0] e;
    while (1) begin
      @(negedge clk);
      if (fcmp_r_tvalid && fcmp_r_tready) break;
      n++;
      if (n > 50) begin
        miscompares++;
        $display("FAIL %s: r_tvalid never rose within 50 cycles, want a result", name);
        return;
      end
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got unexpected result %h, want none", name, fcmp_r_tdata);
    end else begin
      e = exp_q.pop_front();
      if (fcmp_r_tdata !== e) begin
        miscompares++;
        $display("FAIL %s: r_tdata=%h want %h", name, fcmp_r_tdata, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if ({fcmp_r_tvalid, fcmp_r_tdata} !== {1'b0, 8'h00}) begin
      miscompares++; $display("FAIL reset_result: valid/data=%b/%h want 0/00", fcmp_r_tvalid, fcmp_r_tdata);
    end
    vectors++;
    if ({fcmp_a_tready, fcmp_b_tready, fcmp_operation_tready} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_ready: a/b/op=%b%b%b want 111", fcmp_a_tready, fcmp_b_tready, fcmp_operation_tready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_set(32'h3F80_0000, 32'h4000_0000, 8'h0C);
    vectors++;
    if (fcmp_r_tvalid !== 1'b0) begin
      miscompares++; $display("FAIL latency_early: r_tvalid=%b on fill edge, want 0", fcmp_r_tvalid);
    end
    @(posedge clk); #1;
    vectors++;
    if (fcmp_r_tvalid !== 1'b1) begin
      miscompares++; $display("FAIL latency_one: r_tvalid=%b one cycle after fill, want 1", fcmp_r_tvalid);
    end
    pop_check("lt_1_2");
    send_set(32'h3F80_0000, 32'h4000_0000, 8'h1C); pop_check("le_1_2");
    send_set(32'h3F80_0000, 32'h4000_0000, 8'h14); pop_check("eq_1_2");
  endtask

  task automatic test_special();
    send_set(32'h0000_0000, 32'h8000_0000, 8'h14); pop_check("eq_pz_nz");
    send_set(32'h0000_0000, 32'h8000_0000, 8'h0C); pop_check("lt_pz_nz");
    send_set(32'h7FC0_0000, 32'h3F80_0000, 8'h0C); pop_check("lt_nan");
    send_set(32'h7FC0_0000, 32'h3F80_0000, 8'h14); pop_check("eq_nan");
    send_set(32'h7FC0_0000, 32'h3F80_0000, 8'h1C); pop_check("le_nan");
    send_set(32'hFF80_0000, 32'h8000_0001, 8'h0C); pop_check("lt_ninf_nsub");
    send_set(32'h0000_0001, 32'h0000_0002, 8'h1C); pop_check("le_sub");
    send_set(32'h3F80_0000, 32'h3F80_0000, 8'h00); pop_check("op_none");
  endtask

  task automatic test_stagger();
    exp_q.push_back(ref_cmp(32'hC000_0000, 32'hBF80_0000, 8'h0C));
    fcmp_a_tdata = 32'hC000_0000; fcmp_b_tdata = 32'hBF80_0000; fcmp_operation_tdata = 8'h0C;
    for (int cyc = 0; cyc < 9; cyc++) begin
      fcmp_operation_tvalid = (cyc == 0);
      fcmp_a_tvalid = (cyc == 3);
      fcmp_b_tvalid = (cyc == 7);
      @(posedge clk); #1;
      case (cyc)
        0: begin
          vectors++;
          if ({fcmp_operation_tready, fcmp_a_tready} !== 2'b01) begin
            miscompares++; $display("FAIL stagger_op: op/a tready=%b%b want 01", fcmp_operation_tready, fcmp_a_tready);
          end
        end
        3: begin
          vectors++;
          if ({fcmp_a_tready, fcmp_b_tready} !== 2'b01) begin
            miscompares++; $display("FAIL stagger_a: a/b tready=%b%b want 01", fcmp_a_tready, fcmp_b_tready);
          end
        end
        7: begin
          vectors++;
          if ({fcmp_b_tready, fcmp_r_tvalid} !== 2'b00) begin
            miscompares++; $display("FAIL stagger_b: b_tready/r_tvalid=%b%b want 00", fcmp_b_tready, fcmp_r_tvalid);
          end
        end
        8: begin
          vectors++;
          if ({fcmp_r_tvalid, fcmp_a_tready, fcmp_b_tready, fcmp_operation_tready} !== 4'b1111) begin
            miscompares++;
            $display("FAIL stagger_fire: r_tvalid,a,b,op=%b%b%b%b want 1111", fcmp_r_tvalid,
                     fcmp_a_tready, fcmp_b_tready, fcmp_operation_tready);
          end
        end
        default: ;
      endcase
    end
    fcmp_a_tvalid = 1'b0; fcmp_b_tvalid = 1'b0; fcmp_operation_tvalid = 1'b0;
    pop_check("stagger_result");
  endtask

  task automatic test_backpressure();
    logic [OP_W-1:0] e;
    fcmp_r_tready = 1'b0;
    send_set(32'h3F80_0000, 32'h4000_0000, 8'h0C);
    send_set(32'h4000_0000, 32'h3F80_0000, 8'h0C);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (fcmp_r_tvalid !== 1'b1 || fcmp_r_tdata !== exp_q[0] ||
          {fcmp_a_tready, fcmp_b_tready, fcmp_operation_tready} !== 3'b000) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid/data=%b/%h treadys=%b%b%b want 1/%h 000", i, fcmp_r_tvalid,
                 fcmp_r_tdata, fcmp_a_tready, fcmp_b_tready, fcmp_operation_tready, exp_q[0]);
      end
    end
    @(posedge clk); #1;
    fcmp_r_tready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (fcmp_r_tdata !== e) begin
      miscompares++; $display("FAIL bp_first: r_tdata=%h want %h", fcmp_r_tdata, e);
    end
    @(posedge clk); #1;
    vectors++;
    if (fcmp_r_tvalid !== 1'b1 || fcmp_r_tdata !== exp_q[0] || fcmp_a_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_refill: valid/data/a_tready=%b/%h/%b want 1/%h/1", fcmp_r_tvalid, fcmp_r_tdata,
               fcmp_a_tready, exp_q[0]);
    end
    pop_check("bp_second");
  endtask

  task automatic test_reset_mid();
    fcmp_r_tready = 1'b0;
    send_set(32'h0000_0000, 32'h0000_0000, 8'h14);
    @(posedge clk); #1;
    fork
      put_a(32'h3F80_0000, 0);
      put_op(8'h0C, 0);
    join
    vectors++;
    if (fcmp_r_tvalid !== 1'b1) begin
      miscompares++; $display("FAIL rst_pre: r_tvalid=%b want 1", fcmp_r_tvalid);
    end
    rst = 1'b1;
    fcmp_b_tvalid = 1'b1; fcmp_b_tdata = 32'h4000_0000;
    @(posedge clk); #1;
    rst = 1'b0; fcmp_b_tvalid = 1'b0;
    exp_q.delete();
    vectors++;
    if ({fcmp_r_tvalid, fcmp_r_tdata} !== {1'b0, 8'h00} ||
        {fcmp_a_tready, fcmp_b_tready, fcmp_operation_tready} !== 3'b111) begin
      miscompares++;
      $display("FAIL rst_mid: valid/data=%b/%h treadys=%b%b%b want 0/00 111", fcmp_r_tvalid, fcmp_r_tdata,
               fcmp_a_tready, fcmp_b_tready, fcmp_operation_tready);
    end
    fcmp_r_tready = 1'b1;
    put_b(32'h4000_0000, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (fcmp_r_tvalid !== 1'b0) begin
        miscompares++; $display("FAIL rst_b_alone[%0d]: r_tvalid=%b want 0", i, fcmp_r_tvalid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N_RAND; i++) begin
      ra[i] = rnd_fp();
      rb[i] = ($urandom_range(0, 7) == 0) ? ra[i] : rnd_fp();
      case ($urandom_range(0, 5))
        0: rop[i] = 8'h00;
        1: rop[i] = 8'h0C;
        2: rop[i] = 8'h14;
        3: rop[i] = 8'h1C;
        default: rop[i] = OP_W'($urandom);
      endcase
    end
    fork
      for (int i = 0; i < N_RAND; i++) begin
        exp_q.push_back(ref_cmp(ra[i], rb[i], rop[i]));
        put_a(ra[i], $urandom_range(0, 3));
      end
      for (int i = 0; i < N_RAND; i++) put_b(rb[i], $urandom_range(0, 3));
      for (int i = 0; i < N_RAND; i++) put_op(rop[i], $urandom_range(0, 3));
      begin : monitor
        int got = 0;
        int cyc = 0;
        bit stall = 1'b0;
        logic [OP_W-1:0] held, e;
        while (got < N_RAND && cyc < 30000 && !abort) begin
          @(negedge clk);
          cyc++;
          if (stall) begin
            vectors++;
            if (fcmp_r_tvalid !== 1'b1 || fcmp_r_tdata !== held) begin
              miscompares++;
              $display("FAIL rand_hold: valid/data=%b/%h want 1/%h", fcmp_r_tvalid, fcmp_r_tdata, held);
            end
          end
          stall = fcmp_r_tvalid && !fcmp_r_tready;
          held = fcmp_r_tdata;
          if (fcmp_r_tvalid && fcmp_r_tready) begin
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++; $display("FAIL rand_extra: result %h with empty scoreboard", fcmp_r_tdata);
            end else begin
              e = exp_q.pop_front();
              if (fcmp_r_tdata !== e) begin
                miscompares++; $display("FAIL rand_result[%0d]: r_tdata=%h want %h", got, fcmp_r_tdata, e);
              end
            end
            got++;
          end
          @(posedge clk); #1;
          fcmp_r_tready = ($urandom_range(0, 3) != 0);
        end
        if (got < N_RAND) begin
          miscompares++; abort = 1'b1;
          $display("FAIL rand_timeout: %0d results seen, want %0d", got, N_RAND);
        end
      end
    join
    @(negedge clk);
    vectors++;
    if (fcmp_r_tvalid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: r_tvalid=%b pending=%0d want 0/0", fcmp_r_tvalid, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    fcmp_a_tvalid = 1'b0; fcmp_b_tvalid = 1'b0; fcmp_operation_tvalid = 1'b0;
    fcmp_a_tdata = '0; fcmp_b_tdata = '0; fcmp_operation_tdata = '0;
    fcmp_r_tready = 1'b1;
    test_reset();
    test_basic();
    test_special();
    test_stagger();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
